// File: rtl/clk_div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared types and defaults for the programmable clock-divider controller.
//   state_e          : controller state encoding (IDLE/RUN/DRAIN, code 3 unused)
//   CNT_W_DFLT       : default width of counters and config fields
//   DEF_PERIOD_DFLT  : period (clk cycles) in force after reset
//   DEF_HIGH_DFLT    : high cycles per period in force after reset
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int CNT_W_DFLT      = 32;
  localparam int DEF_PERIOD_DFLT = 5;
  localparam int DEF_HIGH_DFLT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl_if
// Configuration handshake between a config source and the divider controller.
//   cfg_valid  : source offers a new period/high pair
//   cfg_ready  : controller can take a configuration this cycle
//   cfg_period : requested period in clk cycles
//   cfg_high   : requested high time in clk cycles
//   cfg_err    : one-cycle pulse, the transferred configuration was rejected
// -----------------------------------------------------------------------------
interface clk_div_ctrl_if
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DFLT
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_err;

  // Config source side
  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_high,
    input  cfg_ready,
    input  cfg_err
  );

  // Divider controller side
  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_high,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/clk_div_ctrl_div_period_counter.sv
// -----------------------------------------------------------------------------
// div_period_counter
// Period counter producing the registered divided waveform and end tick.
//   clk, reset  : system clock, synchronous active-high reset
//   run_i       : controller will be running after the next edge
//   load_i      : restart the period at count 0 on the next edge
//   period_i    : active period (cycles), always >= 2
//   high_i      : active high time (cycles), 1..period_i-1
//   boundary_o  : current cycle is the last of the period (cnt == period-1)
//   div_out_o   : divided waveform, registered
//   tick_o      : high during the last cycle of each period, registered
// -----------------------------------------------------------------------------
module div_period_counter
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DFLT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] high_i,
  output logic             boundary_o,
  output logic             div_out_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1'b1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             div_out_q;
  logic             div_out_d;
  logic             tick_q;
  logic             tick_d;

  assign boundary_o = (cnt_q == (period_i - ONE));
  assign div_out_o  = div_out_q;
  assign tick_o     = tick_q;

  // Next count plus outputs decoded from that next count.
  // The active period/high may only change on an edge where the count
  // restarts at 0, and at count 0 the decode is always div_out=1, tick=0
  // (high>=1, period>=2), so decoding against the current values is exact.
  always_comb begin
    cnt_d     = '0;
    div_out_d = 1'b0;
    tick_d    = 1'b0;
    if (run_i && !load_i) begin
      if (boundary_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = '0;
    end
    if (run_i) begin
      div_out_d = (cnt_d < high_i);
      tick_d    = (cnt_d == (period_i - ONE));
    end else begin
      div_out_d = 1'b0;
      tick_d    = 1'b0;
    end
  end

  // Counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      div_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_out_q <= div_out_d;
      tick_q    <= tick_d;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Run/stop and runtime-reconfiguration controller for the clock divider.
//   clk, reset  : system clock, synchronous active-high reset
//   start_i     : request to run (also cancels a pending stop while draining)
//   stop_i      : request to stop at the end of the current period
//   cfg         : config handshake (slave side), see clk_div_ctrl_if
//   div_out_o   : divided waveform, registered
//   tick_o      : last cycle of each period, registered
//   busy_o      : controller not idle
//   state_o     : current state code, for debug
// New configurations are validated on transfer; accepted ones load directly
// while idle, otherwise wait in shadow registers until the period boundary.
// -----------------------------------------------------------------------------
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DFLT,
  parameter int DEF_PERIOD = DEF_PERIOD_DFLT,
  parameter int DEF_HIGH   = DEF_HIGH_DFLT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic                stop_i,
  clk_div_ctrl_if.slave       cfg,
  output logic                div_out_o,
  output logic                tick_o,
  output logic                busy_o,
  output logic [1:0]          state_o
);

  localparam logic [CNT_W-1:0] TWO = CNT_W'(2'd2);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] act_period_q,  act_period_d;
  logic [CNT_W-1:0] act_high_q,    act_high_d;
  logic [CNT_W-1:0] pend_period_q, pend_period_d;
  logic [CNT_W-1:0] pend_high_q,   pend_high_d;
  logic             pend_vld_q,    pend_vld_d;
  logic             cfg_err_q,     cfg_err_d;

  logic             boundary;
  logic             cnt_run;
  logic             cnt_load;
  logic             cfg_xfer;
  logic             cfg_accept;
  logic             running;

  // A usable config has at least two cycles and both phases non-empty
  function automatic logic cfg_ok(input logic [CNT_W-1:0] period,
                                  input logic [CNT_W-1:0] high);
    return (period >= TWO) && (high != '0) && (high < period);
  endfunction

  assign cfg.cfg_ready = !pend_vld_q;
  assign cfg.cfg_err   = cfg_err_q;
  assign cfg_xfer      = cfg.cfg_valid && !pend_vld_q;
  assign cfg_accept    = cfg_xfer && cfg_ok(cfg.cfg_period, cfg.cfg_high);
  assign running       = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; stop beats start, start while draining cancels the stop
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
        else         state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (stop_i) state_d = ST_DRAIN;
        else        state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (start_i && !stop_i) state_d = ST_RUN;
        else if (boundary)      state_d = ST_IDLE;
        else                    state_d = ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and counter controls
  always_comb begin
    busy_o   = (state_q != ST_IDLE);
    state_o  = state_q;
    cnt_run  = (state_d != ST_IDLE);
    cnt_load = (state_q == ST_IDLE) && (state_d == ST_RUN);
  end

  // Config datapath next state: direct load when idle, shadow-then-boundary
  // when running. A transfer on a boundary cycle with no pending config
  // lands in the shadow and waits for the following boundary.
  always_comb begin
    act_period_d  = act_period_q;
    act_high_d    = act_high_q;
    pend_period_d = pend_period_q;
    pend_high_d   = pend_high_q;
    pend_vld_d    = pend_vld_q;
    cfg_err_d     = cfg_xfer && !cfg_accept;
    if (running) begin
      if (pend_vld_q && boundary) begin
        act_period_d = pend_period_q;
        act_high_d   = pend_high_q;
        pend_vld_d   = 1'b0;
      end else if (cfg_accept) begin
        pend_period_d = cfg.cfg_period;
        pend_high_d   = cfg.cfg_high;
        pend_vld_d    = 1'b1;
      end else begin
        pend_vld_d = pend_vld_q;
      end
    end else begin
      // Idle (or the unused code): nothing may stay pending here
      pend_vld_d = 1'b0;
      if (cfg_accept) begin
        act_period_d = cfg.cfg_period;
        act_high_d   = cfg.cfg_high;
      end else begin
        act_period_d = act_period_q;
      end
    end
  end

  // Config datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      act_period_q  <= CNT_W'(DEF_PERIOD);
      act_high_q    <= CNT_W'(DEF_HIGH);
      pend_period_q <= '0;
      pend_high_q   <= '0;
      pend_vld_q    <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      act_period_q  <= act_period_d;
      act_high_q    <= act_high_d;
      pend_period_q <= pend_period_d;
      pend_high_q   <= pend_high_d;
      pend_vld_q    <= pend_vld_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  div_period_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .run_i      (cnt_run),
    .load_i     (cnt_load),
    .period_i   (act_period_q),
    .high_i     (act_high_q),
    .boundary_o (boundary),
    .div_out_o  (div_out_o),
    .tick_o     (tick_o)
  );

endmodule
